// File: rtl/rf_wr_arb.sv
// rf_wr_arb: two-client register-file write-port arbiter (ALU and load unit).
//
// Ports:
//   clk, reset               - clock, asynchronous active-high reset
//   alu_req/ptr/data/lock    - ALU writeback request, held until granted
//   ld_req/ptr/data/lock     - load-unit writeback request, held until granted
//   alu_gnt, ld_gnt          - combinational grants (one-hot or zero)
//   we, ptr_w, di            - registered register-file write port
//   drop                     - registered pulse: granted write was illegal and discarded
//   drop_cnt                 - saturating drop counter (only with RF_WR_DROP_CNT_EN)
//
// Configuration macro: RF_WR_DROP_CNT_EN adds the drop_cnt output and counter.
module rf_wr_arb (
    input  logic       clk,
    input  logic       reset,
    input  logic       alu_req,
    input  logic [4:0] alu_ptr,
    input  logic [7:0] alu_data,
    input  logic       alu_lock,
    input  logic       ld_req,
    input  logic [4:0] ld_ptr,
    input  logic [7:0] ld_data,
    input  logic       ld_lock,
    output logic       alu_gnt,
    output logic       ld_gnt,
    output logic       we,
    output logic [4:0] ptr_w,
    output logic [7:0] di,
    output logic       drop
`ifdef RF_WR_DROP_CNT_EN
    ,
    output logic [7:0] drop_cnt
`endif
);

    localparam int unsigned PTR_W      = 5;
    localparam int unsigned DATA_W     = 8;
    localparam int unsigned CNT_W      = 8;
    localparam int unsigned LAST_LEGAL = 7;

    typedef enum logic [1:0] {
        ARB      = 2'd0,
        LOCK_ALU = 2'd1,
        LOCK_LD  = 2'd2
    } state_e;

    state_e              state_q, state_d;
    logic                prio_ld_q, prio_ld_d;   // 1: load unit wins a tie
    logic                we_q, we_d;
    logic [PTR_W-1:0]    ptr_w_q, ptr_w_d;
    logic [DATA_W-1:0]   di_q, di_d;
    logic                drop_q, drop_d;

    logic                any_gnt;
    logic [PTR_W-1:0]    sel_ptr;
    logic [DATA_W-1:0]   sel_data;
    logic                sel_lock;
    logic                legal;

    // Grant selection; nothing is granted while reset is asserted.
    always_comb begin
        alu_gnt = 1'b0;
        ld_gnt  = 1'b0;
        if (!reset) begin
            unique case (state_q)
                ARB: begin
                    if (alu_req && ld_req) begin
                        ld_gnt  = prio_ld_q;
                        alu_gnt = !prio_ld_q;
                    end else begin
                        alu_gnt = alu_req;
                        ld_gnt  = ld_req;
                    end
                end
                LOCK_ALU: alu_gnt = alu_req;
                LOCK_LD:  ld_gnt  = ld_req;
                default: begin
                    alu_gnt = 1'b0;
                    ld_gnt  = 1'b0;
                end
            endcase
        end
    end

    // Granted payload mux and legality (only r1..r7 writable).
    always_comb begin
        any_gnt  = alu_gnt | ld_gnt;
        sel_ptr  = ld_gnt ? ld_ptr  : alu_ptr;
        sel_data = ld_gnt ? ld_data : alu_data;
        sel_lock = ld_gnt ? ld_lock : alu_lock;
        legal    = (sel_ptr != '0) && (sel_ptr <= PTR_W'(LAST_LEGAL));
    end

    // Next state: a grant always decides the lock state and flips priority to the other client.
    always_comb begin
        state_d   = state_q;
        prio_ld_d = prio_ld_q;
        we_d      = 1'b0;
        drop_d    = 1'b0;
        ptr_w_d   = ptr_w_q;
        di_d      = di_q;
        if (any_gnt) begin
            prio_ld_d = alu_gnt;
            if (sel_lock) begin
                state_d = alu_gnt ? LOCK_ALU : LOCK_LD;
            end else begin
                state_d = ARB;
            end
            we_d   = legal;
            drop_d = !legal;
            if (legal) begin
                ptr_w_d = sel_ptr;
                di_d    = sel_data;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= ARB;
            prio_ld_q <= 1'b1;
            we_q      <= 1'b0;
            ptr_w_q   <= '0;
            di_q      <= '0;
            drop_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            prio_ld_q <= prio_ld_d;
            we_q      <= we_d;
            ptr_w_q   <= ptr_w_d;
            di_q      <= di_d;
            drop_q    <= drop_d;
        end
    end

    assign we    = we_q;
    assign ptr_w = ptr_w_q;
    assign di    = di_q;
    assign drop  = drop_q;

`ifdef RF_WR_DROP_CNT_EN
    logic [CNT_W-1:0] drop_cnt_q, drop_cnt_d;

    // Counts alongside the drop pulse, saturating at all-ones.
    always_comb begin
        drop_cnt_d = drop_cnt_q;
        if (drop_d && (drop_cnt_q != '1)) begin
            drop_cnt_d = drop_cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            drop_cnt_q <= '0;
        end else begin
            drop_cnt_q <= drop_cnt_d;
        end
    end

    assign drop_cnt = drop_cnt_q;
`endif

endmodule

// File: tb/tb_rf_wr_arb.sv
// tb_rf_wr_arb: directed and random checks of rf_wr_arb against a behavioural model.
module tb_rf_wr_arb;

    logic       clk = 1'b0;
    logic       reset;
    logic       alu_req, alu_lock, ld_req, ld_lock;
    logic [4:0] alu_ptr, ld_ptr;
    logic [7:0] alu_data, ld_data;
    logic       alu_gnt, ld_gnt, we, drop;
    logic [4:0] ptr_w;
    logic [7:0] di;
`ifdef RF_WR_DROP_CNT_EN
    logic [7:0] drop_cnt;
`endif

    always #5 clk = ~clk;

    rf_wr_arb dut (
        .clk      (clk),
        .reset    (reset),
        .alu_req  (alu_req),
        .alu_ptr  (alu_ptr),
        .alu_data (alu_data),
        .alu_lock (alu_lock),
        .ld_req   (ld_req),
        .ld_ptr   (ld_ptr),
        .ld_data  (ld_data),
        .ld_lock  (ld_lock),
        .alu_gnt  (alu_gnt),
        .ld_gnt   (ld_gnt),
        .we       (we),
        .ptr_w    (ptr_w),
        .di       (di),
        .drop     (drop)
`ifdef RF_WR_DROP_CNT_EN
        ,
        .drop_cnt (drop_cnt)
`endif
    );

    int n_cmp = 0;
    int n_err = 0;

    // Model: owner 0=none,1=alu,2=ld; last = client granted most recently.
    int         m_owner, m_last, m_cnt;
    logic       m_we, m_drop;
    logic [4:0] m_ptr;
    logic [7:0] m_di;
    int         last_win;

    // Observed DUT values from the most recent cycle.
    logic       o_alu_gnt, o_ld_gnt, o_we, o_drop;
    logic [4:0] o_ptr;
    logic [7:0] o_di;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_owner = 0;
        m_last  = 1;
        m_cnt   = 0;
        m_we    = 1'b0;
        m_drop  = 1'b0;
        m_ptr   = '0;
        m_di    = '0;
    endtask

    function automatic int model_winner();
        if (reset) return 0;
        if (m_owner == 1) return alu_req ? 1 : 0;
        if (m_owner == 2) return ld_req ? 2 : 0;
        if (alu_req && ld_req) return (m_last == 1) ? 2 : 1;
        if (alu_req) return 1;
        if (ld_req) return 2;
        return 0;
    endfunction

    // One clock: check mid-cycle, advance model, return just after the rising edge.
    task automatic cycle();
        int         w;
        logic [4:0] p;
        logic [7:0] d;
        logic       lk;
        @(negedge clk);
        if (reset) model_reset();
        w = model_winner();
        o_alu_gnt = alu_gnt;
        o_ld_gnt  = ld_gnt;
        o_we      = we;
        o_drop    = drop;
        o_ptr     = ptr_w;
        o_di      = di;
        chk("alu_gnt", 32'(alu_gnt), 32'(w == 1));
        chk("ld_gnt",  32'(ld_gnt),  32'(w == 2));
        chk("we",      32'(we),      32'(m_we));
        chk("ptr_w",   32'(ptr_w),   32'(m_ptr));
        chk("di",      32'(di),      32'(m_di));
        chk("drop",    32'(drop),    32'(m_drop));
`ifdef RF_WR_DROP_CNT_EN
        chk("drop_cnt", 32'(drop_cnt), 32'(m_cnt));
`endif
        last_win = w;
        if (!reset) begin
            if (w != 0) begin
                p  = (w == 1) ? alu_ptr  : ld_ptr;
                d  = (w == 1) ? alu_data : ld_data;
                lk = (w == 1) ? alu_lock : ld_lock;
                m_we   = (p >= 5'd1) && (p <= 5'd7);
                m_drop = !m_we;
                if (m_we) begin
                    m_ptr = p;
                    m_di  = d;
                end else if (m_cnt < 255) begin
                    m_cnt++;
                end
                m_last  = w;
                m_owner = lk ? w : 0;
            end else begin
                m_we   = 1'b0;
                m_drop = 1'b0;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        cycle();
        cycle();
        reset = 1'b0;
    endtask

    task automatic idle();
        alu_req  = 1'b0;
        ld_req   = 1'b0;
        alu_lock = 1'b0;
        ld_lock  = 1'b0;
    endtask

    initial begin
        reset = 1'b1;
        idle();
        alu_ptr = '0; alu_data = '0; ld_ptr = '0; ld_data = '0;
        model_reset();
        last_win = 0;
        @(posedge clk);
        #1;

        // Requests during reset are ignored.
        alu_req = 1'b1; ld_req = 1'b1; alu_ptr = 5'd3; ld_ptr = 5'd2;
        do_reset();
        idle();
        cycle();

        // Single ALU write: grant now, write next cycle, then quiet.
        do_reset();
        alu_req = 1'b1; alu_ptr = 5'd3; alu_data = 8'h5A;
        cycle();
        chk("r029_gnt", 32'(o_alu_gnt), 32'd1);
        idle();
        cycle();
        chk("r029_we",  32'(o_we),  32'd1);
        chk("r029_ptr", 32'(o_ptr), 32'd3);
        chk("r029_di",  32'(o_di),  32'h5A);
        cycle();
        chk("r029_we_off", 32'(o_we), 32'd0);

        // Continuous contention alternates starting with the load unit.
        do_reset();
        ld_req = 1'b1; ld_ptr = 5'd2; ld_data = 8'h22;
        alu_req = 1'b1; alu_ptr = 5'd4; alu_data = 8'h44;
        for (int i = 0; i < 6; i++) begin
            cycle();
            chk("r030_ld_gnt", 32'(o_ld_gnt), 32'((i % 2) == 0));
            if (i > 0) chk("r030_ptr", 32'(o_ptr), (i % 2) == 1 ? 32'd2 : 32'd4);
        end
        idle();
        cycle();

        // Load lock held for three grants keeps the ALU waiting.
        do_reset();
        alu_req = 1'b1; alu_ptr = 5'd5; alu_data = 8'h55;
        ld_req = 1'b1; ld_ptr = 5'd6; ld_data = 8'h66;
        for (int i = 0; i < 5; i++) begin
            ld_lock = (i < 3);
            if (i == 4) ld_req = 1'b0;
            cycle();
            chk("r031_ld_gnt",  32'(o_ld_gnt),  32'(i < 4));
            chk("r031_alu_gnt", 32'(o_alu_gnt), 32'(i == 4));
        end
        idle();
        cycle();
        cycle();

        // Illegal pointers are consumed and dropped.
        do_reset();
        alu_req = 1'b1; alu_data = 8'hEE;
        for (int i = 0; i < 4; i++) begin
            if (i == 0) alu_ptr = 5'd0;
            if (i == 1) alu_ptr = 5'd8;
            if (i == 2) alu_ptr = 5'd12;
            if (i == 3) idle();
            cycle();
            if (i > 0) begin
                chk("r032_drop", 32'(o_drop), 32'd1);
                chk("r032_we",   32'(o_we),   32'd0);
            end
        end
`ifdef RF_WR_DROP_CNT_EN
        chk("r032_cnt", 32'(drop_cnt), 32'd3);
`endif
        cycle();

        // Reset mid-lock with a write pending discards it and restores load priority.
        do_reset();
        alu_req = 1'b1; alu_lock = 1'b1; alu_ptr = 5'd7; alu_data = 8'h77;
        cycle();
        idle();
        reset = 1'b1;
        cycle();
        chk("r033_we", 32'(o_we), 32'd0);
        reset = 1'b0;
        cycle();
        chk("r033_we_after", 32'(o_we), 32'd0);
        alu_req = 1'b1; alu_ptr = 5'd1; ld_req = 1'b1; ld_ptr = 5'd2;
        cycle();
        chk("r033_ld_first", 32'(o_ld_gnt), 32'd1);
        idle();
        cycle();
        cycle();

        // Random traffic with holding requests and occasional reset pulses.
        do_reset();
        for (int i = 0; i < 600; i++) begin
            reset = ($urandom_range(63) == 0);
            if (!alu_req || last_win == 1) begin
                alu_req  = ($urandom_range(3) != 0);
                alu_ptr  = ($urandom_range(3) == 0) ? 5'($urandom) : 5'($urandom_range(7, 1));
                alu_data = 8'($urandom);
                alu_lock = ($urandom_range(3) == 0);
            end
            if (!ld_req || last_win == 2) begin
                ld_req  = ($urandom_range(3) != 0);
                ld_ptr  = ($urandom_range(3) == 0) ? 5'($urandom) : 5'($urandom_range(7, 1));
                ld_data = 8'($urandom);
                ld_lock = ($urandom_range(3) == 0);
            end
            cycle();
        end
        reset = 1'b0;
        idle();
        cycle();

`ifdef RF_WR_DROP_CNT_EN
        // Drop counter saturates at 255.
        do_reset();
        alu_req = 1'b1; alu_ptr = 5'd0;
        for (int i = 0; i < 300; i++) cycle();
        chk("r034_sat", 32'(drop_cnt), 32'd255);
        cycle();
        chk("r034_hold", 32'(drop_cnt), 32'd255);
        idle();
        cycle();
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
